// File: rtl/tt_board_harness.sv
// Board-side adapter between FPGA pins and a Tiny Tapeout user design: input sync, switch
// debounce, DUT clock-enable generation and LED drive. Optional LED pulse stretch: HARNESS_STRETCH_EN.
module tt_board_harness #(
    parameter int N_SW            = 4,
    parameter int N_IN            = 8,
    parameter int N_OUT           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DIV_WIDTH       = 16,
    parameter int SW_ACTIVE_LOW   = 1,
    parameter int OUT_ACTIVE_LOW  = 1,
    parameter int STRETCH_CYCLES  = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SW-1:0]      sw_raw,
    input  logic [N_IN-1:0]      pin_raw,
    input  logic                 step_btn,
    input  logic                 mode_run,
    input  logic [DIV_WIDTH-1:0] div_sel,
    output logic [N_IN-1:0]      dut_ui_in,
    output logic [N_SW-1:0]      dut_uio_in,
    output logic                 dut_clk_en,
    input  logic [N_OUT-1:0]     dut_uo_out,
    output logic [N_OUT-1:0]     led
);

    localparam int NDB  = N_SW + 1;
    localparam int SY_W = N_IN + NDB + 1;
    localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_OUT-1:0] LED_OFF = (OUT_ACTIVE_LOW != 0) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};

    logic [NDB-1:0]       db_raw_s;
    logic [SY_W-1:0]      sync_q [SYNC_STAGES];
    logic [SY_W-1:0]      synced_s;
    logic [NDB-1:0]       db_sync_s;
    logic                 mode_s;
    logic [DBW-1:0]       db_cnt_q [NDB];
    logic [DBW-1:0]       db_cnt_d [NDB];
    logic [NDB-1:0]       db_stable_q, db_stable_d;
    logic                 step_prev_q, mode_prev_q;
    logic                 step_rise_s, mode_edge_s;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 clk_en_q, clk_en_d;
    logic [N_OUT-1:0]     lit_s, led_d, led_q;

    // Logical polarity is fixed before synchronisation so everything downstream is active-high.
    assign db_raw_s = (SW_ACTIVE_LOW != 0) ? ~{step_btn, sw_raw} : {step_btn, sw_raw};

    // Synchroniser chain shared by the Pmod pins, switches, step button and mode select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= {mode_run, db_raw_s, pin_raw};
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced_s  = sync_q[SYNC_STAGES-1];
    assign db_sync_s = synced_s[N_IN +: NDB];
    assign mode_s    = synced_s[SY_W-1];

    // Debounce: a change is accepted only after it has held for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        for (int i = 0; i < NDB; i++) begin
            db_cnt_d[i]    = db_cnt_q[i];
            db_stable_d[i] = db_stable_q[i];
            if (db_sync_s[i] == db_stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_stable_d[i] = db_sync_s[i];
                db_cnt_d[i]    = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign step_rise_s = db_stable_q[N_SW] & ~step_prev_q;
    assign mode_edge_s = mode_s ^ mode_prev_q;

    // Clock-enable source: a mode change resets the divider and swallows that cycle's strobe.
    always_comb begin
        div_cnt_d = div_cnt_q;
        clk_en_d  = 1'b0;
        if (mode_edge_s) begin
            div_cnt_d = '0;
            clk_en_d  = 1'b0;
        end else if (mode_s) begin
            if (div_cnt_q >= div_sel) begin
                div_cnt_d = '0;
                clk_en_d  = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                clk_en_d  = 1'b0;
            end
        end else begin
            div_cnt_d = '0;
            clk_en_d  = step_rise_s;
        end
    end

`ifdef HARNESS_STRETCH_EN
    localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_CYCLES - 1);

    logic [STR_W-1:0] str_cnt_q [N_OUT];
    logic [STR_W-1:0] str_cnt_d [N_OUT];
    logic [N_OUT-1:0] uo_prev_q;

    // Pulse stretch: a rising output (re)arms the counter; the LED stays lit until it drains.
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            if (dut_uo_out[i] & ~uo_prev_q[i]) begin
                str_cnt_d[i] = STR_LOAD;
            end else if (str_cnt_q[i] != '0) begin
                str_cnt_d[i] = str_cnt_q[i] - 1'b1;
            end else begin
                str_cnt_d[i] = str_cnt_q[i];
            end
            lit_s[i] = dut_uo_out[i] | (str_cnt_q[i] != '0);
        end
    end

    // Stretch counter and previous-output state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uo_prev_q <= '0;
            for (int i = 0; i < N_OUT; i++) str_cnt_q[i] <= '0;
        end else begin
            uo_prev_q <= dut_uo_out;
            for (int i = 0; i < N_OUT; i++) str_cnt_q[i] <= str_cnt_d[i];
        end
    end
`else
    assign lit_s = dut_uo_out;
`endif

    assign led_d = (OUT_ACTIVE_LOW != 0) ? ~lit_s : lit_s;

    // Debounce, edge-detect, divider, strobe and LED registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NDB; i++) db_cnt_q[i] <= '0;
            db_stable_q <= '0;
            step_prev_q <= 1'b0;
            mode_prev_q <= 1'b0;
            div_cnt_q   <= '0;
            clk_en_q    <= 1'b0;
            led_q       <= LED_OFF;
        end else begin
            for (int i = 0; i < NDB; i++) db_cnt_q[i] <= db_cnt_d[i];
            db_stable_q <= db_stable_d;
            step_prev_q <= db_stable_q[N_SW];
            mode_prev_q <= mode_s;
            div_cnt_q   <= div_cnt_d;
            clk_en_q    <= clk_en_d;
            led_q       <= led_d;
        end
    end

    assign dut_ui_in  = synced_s[N_IN-1:0];
    assign dut_uio_in = db_stable_q[N_SW-1:0];
    assign dut_clk_en = clk_en_q;
    assign led        = led_q;

endmodule

// File: tb/tb_tt_board_harness.sv
// Directed self-checking bench for tt_board_harness (DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8).
module tb_tt_board_harness;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_raw;
    logic [7:0]  pin_raw;
    logic        step_btn;
    logic        mode_run;
    logic [15:0] div_sel;
    logic [7:0]  dut_ui_in;
    logic [3:0]  dut_uio_in;
    logic        dut_clk_en;
    logic [7:0]  dut_uo_out;
    logic [7:0]  led;

    int checks   = 0;
    int failures = 0;

    tt_board_harness #(
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .pin_raw   (pin_raw),
        .step_btn  (step_btn),
        .mode_run  (mode_run),
        .div_sel   (div_sel),
        .dut_ui_in (dut_ui_in),
        .dut_uio_in(dut_uio_in),
        .dut_clk_en(dut_clk_en),
        .dut_uo_out(dut_uo_out),
        .led       (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pin;
        logic [7:0] uo;
        logic [7:0] exp_ui;
        logic [7:0] exp_led;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (dut_clk_en !== 1'b1 && n < budget);
        chk(name, {31'd0, dut_clk_en}, 32'd1);
    endtask

    initial begin
        int pulses;
        int first_at;

        tbl[0] = '{8'hA5, 8'h0F, 8'h00, 8'hF0};
        tbl[1] = '{8'h3C, 8'h00, 8'hA5, 8'hFF};
        tbl[2] = '{8'h3C, 8'hFF, 8'h3C, 8'h00};
        tbl[3] = '{8'h00, 8'h81, 8'h3C, 8'h7E};
        tbl[4] = '{8'hFF, 8'h5A, 8'h00, 8'hA5};
        tbl[5] = '{8'hFF, 8'h5A, 8'hFF, 8'hA5};

        sw_raw     = 4'hF;
        pin_raw    = 8'h00;
        step_btn   = 1'b1;
        mode_run   = 1'b0;
        div_sel    = 16'd0;
        dut_uo_out = 8'h00;
        rst        = 1'b1;
        repeat (3) tick();
        chk("reset_led", {24'd0, led}, 32'hFF);
        chk("reset_en", {31'd0, dut_clk_en}, 32'd0);
        chk("reset_ui", {24'd0, dut_ui_in}, 32'd0);
        chk("reset_uio", {28'd0, dut_uio_in}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Pin synchroniser latency and LED pass-through.
        for (int i = 0; i < 6; i++) begin
            pin_raw    = tbl[i].pin;
            dut_uo_out = tbl[i].uo;
            tick();
            chk($sformatf("ui_vec%0d", i), {24'd0, dut_ui_in}, {24'd0, tbl[i].exp_ui});
`ifndef HARNESS_STRETCH_EN
            chk($sformatf("led_vec%0d", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
`endif
        end
        dut_uo_out = 8'h00;

        // Switch debounce: accepted SYNC_STAGES+4 cycles after the press.
        sw_raw[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("db_press_t%0d", k), {31'd0, dut_uio_in[0]}, {31'd0, k >= 6});
        end
        sw_raw[0] = 1'b1;
        tick();
        tick();
        sw_raw[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("db_glitch_t%0d", k), {31'd0, dut_uio_in[0]}, 32'd1);
        end

        // Run mode, period div_sel+1.
        mode_run = 1'b1;
        div_sel  = 16'd3;
        wait_pulse("run_first_pulse", 20);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("run_div3_t%0d", k), {31'd0, dut_clk_en}, {31'd0, (k % 4) == 0});
        end
        div_sel = 16'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("run_div0_t%0d", k), {31'd0, dut_clk_en}, 32'd1);
        end
        div_sel = 16'd9;
        wait_pulse("run_div9_pulse", 30);
        repeat (5) tick();
        chk("run_div9_count5", {31'd0, dut_clk_en}, 32'd0);
        div_sel = 16'd2;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("run_lower_t%0d", k), {31'd0, dut_clk_en}, {31'd0, k == 1 || k == 4});
        end

        // Single-step mode: one strobe per debounced press.
        mode_run = 1'b0;
        repeat (6) tick();
        step_btn = 1'b0;
        pulses   = 0;
        first_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dut_clk_en === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
        chk("step_hold_pulses", pulses, 32'd1);
        chk("step_latency", first_at, 32'd7);
        step_btn = 1'b1;
        pulses   = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (dut_clk_en === 1'b1) pulses++;
        end
        chk("step_release_pulses", pulses, 32'd0);
        step_btn = 1'b0;
        pulses   = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (dut_clk_en === 1'b1) pulses++;
        end
        chk("step_second_pulses", pulses, 32'd1);
        step_btn = 1'b1;
        repeat (10) tick();

        // Asynchronous reset mid-operation.
        mode_run   = 1'b1;
        div_sel    = 16'd0;
        dut_uo_out = 8'h0F;
        repeat (4) tick();
`ifndef HARNESS_STRETCH_EN
        chk("pre_rst_led", {24'd0, led}, 32'hF0);
`endif
        chk("pre_rst_en", {31'd0, dut_clk_en}, 32'd1);
        chk("pre_rst_uio", {28'd0, dut_uio_in}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_led", {24'd0, led}, 32'hFF);
        chk("rst_async_en", {31'd0, dut_clk_en}, 32'd0);
        chk("rst_async_uio", {28'd0, dut_uio_in}, 32'd0);
        rst        = 1'b0;
        dut_uo_out = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("post_rst_en_t%0d", k), {31'd0, dut_clk_en}, {31'd0, k >= 4});
            chk($sformatf("post_rst_uio_t%0d", k), {31'd0, dut_uio_in[0]}, {31'd0, k >= 6});
        end

`ifdef HARNESS_STRETCH_EN
        // LED stretch with a retrigger four cycles after the first pulse.
        repeat (10) tick();
        for (int k = 1; k <= 14; k++) begin
            dut_uo_out = (k == 1 || k == 5) ? 8'h04 : 8'h00;
            tick();
            chk($sformatf("stretch_t%0d", k), {31'd0, led[2]}, {31'd0, k >= 13});
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
